// File: rtl/collision_monitor.sv
// Multi-bike collision monitor: samples two probe pixels ahead of each bike's nose during the VGA scan,
// debounces per-frame hits over HIT_FRAMES frames and reports new crashes through a valid/ack event.
module collision_monitor #(
  parameter int NUM_BIKES   = 2,
  parameter int ADDR_W      = 19,
  parameter int COLOR_W     = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PROBE_AHEAD = 16,
  parameter int PROBE_SIDE  = 5,
  parameter int HIT_FRAMES  = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pixel_valid,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [COLOR_W-1:0]            pixel_color,
  input  logic [COLOR_W-1:0]            road_color,
  input  logic [NUM_BIKES-1:0]          bike_active,
  input  logic [NUM_BIKES*ADDR_W-1:0]   bike_locs,
  input  logic [NUM_BIKES*2-1:0]        bike_orients,
  input  logic [NUM_BIKES-1:0]          clear_collided,
  input  logic                          event_ack,
  output logic [NUM_BIKES-1:0]          collided,
  output logic [NUM_BIKES-1:0]          frame_hits,
  output logic                          event_valid,
  output logic [NUM_BIKES-1:0]          event_mask,
  output logic [1:0]                    dbg_state_o
);

  localparam int PW    = ADDR_W + 2;
  localparam int CNT_W = $clog2(HIT_FRAMES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic signed [PW-1:0] OFF_D  = PW'(PROBE_AHEAD);
  localparam logic signed [PW-1:0] OFF_DW = PW'(PROBE_AHEAD * H_RES);
  localparam logic signed [PW-1:0] OFF_S  = PW'(PROBE_SIDE);
  localparam logic signed [PW-1:0] OFF_SW = PW'(PROBE_SIDE * H_RES);
  localparam logic signed [PW-1:0] SCREEN = PW'(H_RES * V_RES);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(HIT_FRAMES);

  logic [1:0]                        state_q, state_d;
  logic [NUM_BIKES*ADDR_W-1:0]       loc_q, loc_d;
  logic [NUM_BIKES*2-1:0]            ori_q, ori_d;
  logic [NUM_BIKES-1:0]              act_q, act_d;
  logic [NUM_BIKES-1:0]              hit_acc_q, hit_acc_d;
  logic [NUM_BIKES-1:0]              frame_hits_q, frame_hits_d;
  logic [NUM_BIKES-1:0]              collided_q, collided_d;
  logic [NUM_BIKES-1:0]              pending_q, pending_d;
  logic [NUM_BIKES-1:0][CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_BIKES-1:0]              wall;
  logic [NUM_BIKES-1:0]              pix_hit;
  logic [NUM_BIKES-1:0]              new_set;

  // Probe geometry comes only from the frame snapshot, never from the live bike inputs.
  for (genvar g = 0; g < NUM_BIKES; g++) begin : g_probe
    logic signed [PW-1:0] mid;
    logic signed [PW-1:0] base;
    logic signed [PW-1:0] side;
    logic signed [PW-1:0] pa;
    logic signed [PW-1:0] pb;
    logic                 oor_a;
    logic                 oor_b;

    always_comb begin
      mid  = $signed({2'b00, loc_q[g*ADDR_W +: ADDR_W]});
      base = mid;
      side = OFF_S;
      case (ori_q[2*g +: 2])
        2'd0: begin
          base = mid - OFF_DW;
          side = OFF_S;
        end
        2'd1: begin
          base = mid - OFF_D;
          side = OFF_SW;
        end
        2'd2: begin
          base = mid + OFF_DW;
          side = OFF_S;
        end
        default: begin
          base = mid + OFF_D;
          side = OFF_SW;
        end
      endcase
      pa    = base - side;
      pb    = base + side;
      oor_a = pa[PW-1] || (pa >= SCREEN);
      oor_b = pb[PW-1] || (pb >= SCREEN);
    end

    assign wall[g]    = act_q[g] & (oor_a | oor_b);
    assign pix_hit[g] = act_q[g] & pixel_valid & (pixel_color != road_color) &
                        ((!oor_a && (addr == pa[ADDR_W-1:0])) ||
                         (!oor_b && (addr == pb[ADDR_W-1:0])));
  end

  always_comb begin
    state_d      = state_q;
    loc_d        = loc_q;
    ori_d        = ori_q;
    act_d        = act_q;
    hit_acc_d    = hit_acc_q;
    frame_hits_d = frame_hits_q;
    cnt_d        = cnt_q;
    collided_d   = collided_q;
    pending_d    = pending_q;
    new_set      = '0;

    if (frame_start && (state_q != ST_COMMIT)) begin
      loc_d = bike_locs;
      ori_d = bike_orients;
      act_d = bike_active;
    end

    case (state_q)
      ST_IDLE: begin
        hit_acc_d = '0;
        if (frame_start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Wall hits are folded in with the closing snapshot, before it is replaced.
        if (frame_start) begin
          hit_acc_d = hit_acc_q | wall;
          state_d   = ST_COMMIT;
        end else begin
          hit_acc_d = hit_acc_q | pix_hit;
        end
      end
      ST_COMMIT: begin
        state_d      = ST_SCAN;
        hit_acc_d    = '0;
        frame_hits_d = hit_acc_q;
        for (int i = 0; i < NUM_BIKES; i++) begin
          if (hit_acc_q[i]) begin
            cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
          end else begin
            cnt_d[i] = '0;
          end
          new_set[i] = (cnt_d[i] == CNT_MAX) && !collided_q[i];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear on the same cycle as a commit suppresses that commit's set.
    for (int i = 0; i < NUM_BIKES; i++) begin
      if (clear_collided[i]) cnt_d[i] = '0;
    end
    new_set    = new_set & ~clear_collided;
    collided_d = (collided_q | new_set) & ~clear_collided;

    if (event_valid && event_ack) pending_d = '0;
    pending_d = pending_d | new_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      loc_q        <= '0;
      ori_q        <= '0;
      act_q        <= '0;
      hit_acc_q    <= '0;
      frame_hits_q <= '0;
      cnt_q        <= '0;
      collided_q   <= '0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      loc_q        <= loc_d;
      ori_q        <= ori_d;
      act_q        <= act_d;
      hit_acc_q    <= hit_acc_d;
      frame_hits_q <= frame_hits_d;
      cnt_q        <= cnt_d;
      collided_q   <= collided_d;
      pending_q    <= pending_d;
    end
  end

  // Event handshake: event_valid = |pending; event_valid & event_ack retires every bit that
  // was pending, while bits set by a commit on that same cycle survive into the next event.
  assign collided    = collided_q;
  assign frame_hits  = frame_hits_q;
  assign event_valid = |pending_q;
  assign event_mask  = pending_q;
  assign dbg_state_o = state_q;

endmodule
